cond_unit: RTL and testbench



---
 rtl/cond_unit_pkg.sv | 33 +++
 rtl/cond_eval.sv | 39 +++
 rtl/cond_unit.sv | 113 +++++++++++
 tb/tb_cond_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_unit_pkg.sv
// Shared condition-code encodings and NZCV bit positions for the execute-stage
// conditional-execution logic.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_code_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Bit positions within flag_w_e
    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against NZCV flags.
module cond_eval
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond_code_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = ~z & c;
            COND_LS: pass = z | ~c;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional-execution unit: NZCV flags register, control gating,
// E/M pipeline register for gated controls, and saturating retire counters.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_e,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_w_e,
    input  logic [3:0]       alu_flags_e,
    input  logic             pcs_e,
    input  logic             reg_w_e,
    input  logic             mem_w_e,
    input  logic             no_write_e,
    input  logic             clr_cnt,
    output logic             cond_ex_e,
    output logic             pc_src_e,
    output logic [3:0]       flags,
    output logic             pc_src_m,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       flags_d, flags_q;
    logic             pc_src_m_d, pc_src_m_q;
    logic             reg_write_m_d, reg_write_m_q;
    logic             mem_write_m_d, mem_write_m_q;
    logic [CNT_W-1:0] exec_cnt_d, exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;
    logic             retire;

    // Evaluated against the architectural flags only; no forwarding from the ALU.
    cond_eval u_cond_eval (
        .cond  (cond_e),
        .flags (flags_q),
        .pass  (cond_ex_e)
    );

    assign retire   = valid_e & ~stall_e & ~flush_e;
    assign pc_src_e = pcs_e & cond_ex_e & valid_e & ~flush_e;

    always_comb begin
        flags_d = flags_q;
        if (retire && cond_ex_e) begin
            if (flag_w_e[FW_NZ]) begin
                flags_d[FLAG_N] = alu_flags_e[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
            end
            if (flag_w_e[FW_CV]) begin
                flags_d[FLAG_C] = alu_flags_e[FLAG_C];
                flags_d[FLAG_V] = alu_flags_e[FLAG_V];
            end
        end
    end

    // Anything that does not retire enters M as a bubble.
    always_comb begin
        pc_src_m_d    = retire & pcs_e & cond_ex_e;
        reg_write_m_d = retire & reg_w_e & ~no_write_e & cond_ex_e;
        mem_write_m_d = retire & mem_w_e & cond_ex_e;
    end

    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (clr_cnt) begin
            exec_cnt_d   = '0;
            squash_cnt_d = '0;
        end else if (retire) begin
            if (cond_ex_e) begin
                if (exec_cnt_q != CntMax) exec_cnt_d = exec_cnt_q + CntOne;
            end else begin
                if (squash_cnt_q != CntMax) squash_cnt_d = squash_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= 4'b0000;
            pc_src_m_q    <= 1'b0;
            reg_write_m_q <= 1'b0;
            mem_write_m_q <= 1'b0;
            exec_cnt_q    <= '0;
            squash_cnt_q  <= '0;
        end else begin
            flags_q       <= flags_d;
            pc_src_m_q    <= pc_src_m_d;
            reg_write_m_q <= reg_write_m_d;
            mem_write_m_q <= mem_write_m_d;
            exec_cnt_q    <= exec_cnt_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    assign flags       = flags_q;
    assign pc_src_m    = pc_src_m_q;
    assign reg_write_m = reg_write_m_q;
    assign mem_write_m = mem_write_m_q;
    assign exec_cnt    = exec_cnt_q;
    assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes hand-computed expectations,
// a monitor pops and compares them at each sample point.
module tb_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_e, stall_e, flush_e;
    logic [3:0]  cond_e;
    logic [1:0]  flag_w_e;
    logic [3:0]  alu_flags_e;
    logic        pcs_e, reg_w_e, mem_w_e, no_write_e, clr_cnt;
    logic        cond_ex_e, pc_src_e;
    logic [3:0]  flags;
    logic        pc_src_m, reg_write_m, mem_write_m;
    logic [15:0] exec_cnt, squash_cnt;

    cond_unit #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_e     (valid_e),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .cond_e      (cond_e),
        .flag_w_e    (flag_w_e),
        .alu_flags_e (alu_flags_e),
        .pcs_e       (pcs_e),
        .reg_w_e     (reg_w_e),
        .mem_w_e     (mem_w_e),
        .no_write_e  (no_write_e),
        .clr_cnt     (clr_cnt),
        .cond_ex_e   (cond_ex_e),
        .pc_src_e    (pc_src_e),
        .flags       (flags),
        .pc_src_m    (pc_src_m),
        .reg_write_m (reg_write_m),
        .mem_write_m (mem_write_m),
        .exec_cnt    (exec_cnt),
        .squash_cnt  (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        cex;
        logic        pcse;
        logic [3:0]  fl;
        logic        pcm;
        logic        rwm;
        logic        mwm;
        logic [15:0] ec;
        logic [15:0] sc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic cex, input logic pcse,
                        input logic [3:0] fl, input logic pcm, input logic rwm,
                        input logic mwm, input logic [15:0] ec, input logic [15:0] sc);
        exp_t e;
        e.tag = tag; e.cex = cex; e.pcse = pcse; e.fl = fl;
        e.pcm = pcm; e.rwm = rwm; e.mwm = mwm; e.ec = ec; e.sc = sc;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] af, input logic pcs,
                         input logic rw, input logic mw, input logic nw, input logic clr);
        valid_e = v; stall_e = st; flush_e = fl; cond_e = cond; flag_w_e = fw;
        alu_flags_e = af; pcs_e = pcs; reg_w_e = rw; mem_w_e = mw; no_write_e = nw;
        clr_cnt = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples after the falling clock edge, or right after an async reset.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk(e.tag, "cond_ex_e",   {15'd0, cond_ex_e},   {15'd0, e.cex});
                chk(e.tag, "pc_src_e",    {15'd0, pc_src_e},    {15'd0, e.pcse});
                chk(e.tag, "flags",       {12'd0, flags},       {12'd0, e.fl});
                chk(e.tag, "pc_src_m",    {15'd0, pc_src_m},    {15'd0, e.pcm});
                chk(e.tag, "reg_write_m", {15'd0, reg_write_m}, {15'd0, e.rwm});
                chk(e.tag, "mem_write_m", {15'd0, mem_write_m}, {15'd0, e.mwm});
                chk(e.tag, "exec_cnt",    exec_cnt,             e.ec);
                chk(e.tag, "squash_cnt",  squash_cnt,           e.sc);
            end
        end
    end

    initial begin
        logic [15:0] tbl;
        // Pass bit per condition code with flags N=0 Z=0 C=1 V=1
        tbl = 16'b0110_1001_0110_0110;

        rst_n = 1'b0;
        drive(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        tick();
        push("reset", 0, 0, 4'h0, 0, 0, 0, 16'd0, 16'd0);
        tick();
        rst_n = 1'b1;

        // EQ after reset fails
        drive(1, 0, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        push("eq_reset", 0, 0, 4'h0, 0, 0, 0, 16'd0, 16'd0);
        tick();
        drive(0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("eq_reset_m", 1, 0, 4'h0, 0, 0, 0, 16'd0, 16'd1);
        tick();

        // CMP sets Z, next instruction consumes it
        drive(1, 0, 0, 4'hE, 2'b11, 4'b0100, 0, 1, 0, 1, 0);
        push("cmp", 1, 0, 4'h0, 0, 0, 0, 16'd0, 16'd1);
        tick();
        drive(1, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 1, 0, 0);
        push("eq_use", 1, 0, 4'b0100, 0, 0, 0, 16'd1, 16'd1);
        tick();
        drive(0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("eq_use_m", 1, 0, 4'b0100, 0, 0, 1, 16'd2, 16'd1);
        tick();

        // Partial flag write
        drive(1, 0, 0, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 0);
        push("set_all", 1, 0, 4'b0100, 0, 0, 0, 16'd2, 16'd1);
        tick();
        drive(1, 0, 0, 4'hE, 2'b10, 4'b0000, 0, 0, 0, 0, 0);
        push("part_nz", 1, 0, 4'b1111, 0, 0, 0, 16'd3, 16'd1);
        tick();
        // GE fails; its own flag write must be dropped
        drive(1, 0, 0, 4'hA, 2'b11, 4'b1000, 1, 1, 0, 0, 0);
        push("ge_fail", 0, 0, 4'b0011, 0, 0, 0, 16'd4, 16'd1);
        tick();
        drive(0, 0, 0, 4'hB, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("lt_pass", 1, 0, 4'b0011, 0, 0, 0, 16'd4, 16'd2);
        tick();

        // Stall + flush, then stall only, then release
        drive(1, 1, 1, 4'hE, 2'b11, 4'b1111, 1, 1, 0, 0, 0);
        push("stall_flush", 1, 0, 4'b0011, 0, 0, 0, 16'd4, 16'd2);
        tick();
        drive(1, 1, 0, 4'hE, 2'b11, 4'b1111, 1, 1, 0, 0, 0);
        push("stall_1", 1, 1, 4'b0011, 0, 0, 0, 16'd4, 16'd2);
        tick();
        push("stall_2", 1, 1, 4'b0011, 0, 0, 0, 16'd4, 16'd2);
        tick();
        drive(1, 0, 0, 4'hE, 2'b00, 4'h0, 1, 1, 0, 0, 0);
        push("release", 1, 1, 4'b0011, 0, 0, 0, 16'd4, 16'd2);
        tick();
        drive(0, 0, 0, 4'h1, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("release_m", 1, 0, 4'b0011, 1, 1, 0, 16'd5, 16'd2);
        tick();

        // All condition codes against flags 0011
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 4'(i), 2'b00, 4'h0, 1, 0, 0, 0, 0);
            push($sformatf("cond_%0d", i), tbl[i], 0, 4'b0011, 0, 0, 0, 16'd5, 16'd2);
            tick();
        end

        // Clear, fill exec_cnt to all-ones, check saturation and clear priority
        drive(0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 1);
        push("clr", 1, 0, 4'b0011, 0, 0, 0, 16'd5, 16'd2);
        tick();
        drive(1, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) tick();
        push("sat_full", 1, 0, 4'b0011, 0, 0, 0, 16'hFFFF, 16'd0);
        tick();
        drive(1, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 1);
        push("sat_hold", 0, 0, 4'b0011, 0, 0, 0, 16'hFFFF, 16'd0);
        tick();
        drive(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("clr_prio", 0, 0, 4'b0011, 0, 0, 0, 16'd0, 16'd0);
        tick();

        // Async reset between edges
        drive(1, 0, 0, 4'hE, 2'b11, 4'b1010, 0, 1, 0, 0, 0);
        push("pre_set", 1, 0, 4'b0011, 0, 0, 0, 16'd0, 16'd0);
        tick();
        drive(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("pre_rst", 0, 0, 4'b1010, 0, 1, 0, 16'd1, 16'd0);
        @(negedge clk);
        #2;
        push("async_rst", 0, 0, 4'h0, 0, 0, 0, 16'd0, 16'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1, 0, 0, 4'h1, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        push("post_ne", 1, 0, 4'h0, 0, 0, 0, 16'd0, 16'd0);
        tick();
        drive(1, 0, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        push("post_eq", 0, 0, 4'h0, 0, 1, 0, 16'd1, 16'd0);
        tick();
        drive(0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        push("post_eq_m", 1, 0, 4'h0, 0, 0, 0, 16'd1, 16'd1);
        tick();

        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
        #2;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
